// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
// Command-decoded single-port RAM that sits between an SPI slave's receive
// shift logic and its transmit path. Each accepted rx word is {cmd, payload}:
//   00 set write address   01 write data (at wr_add)
//   10 set read address    11 read data  (from rd_add, returned on dout)
// Address pointers optionally auto-increment, wrapping at MEM_DEPTH. Any
// write or read that uses an address outside the memory raises a one-cycle
// err pulse; such writes are dropped and such reads return zero.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   din       rx word, din[DATA_W+1:DATA_W] = cmd, din[DATA_W-1:0] = payload
//   rx_valid  din valid this cycle
//   rx_ready  block accepts din this cycle (high only when idle)
//   dout      read data, stable while tx_valid is high, held afterwards
//   tx_valid  dout valid, held until taken
//   tx_ready  consumer takes dout when tx_valid & tx_ready
//   err       one-cycle pulse for an out-of-range write or read
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Depth and last index expressed at pointer width for range compares.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(MEM_DEPTH - 1);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_MEM = 2'd1,
        ST_RD_OUT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   wr_add_r;
    logic [ADDR_W-1:0]   rd_add_r;
    logic [DATA_W-1:0]   dout_r;
    logic                tx_valid_r;
    logic                err_r;
    logic [DATA_W-1:0]   mem_r [MEM_DEPTH];

    logic [1:0]          cmd_s;
    logic [DATA_W-1:0]   payload_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                accept_s;
    logic                wr_in_range_s;
    logic                rd_in_range_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [IDX_W-1:0]    rd_idx_s;

    // Pointer advance, wrapping at the memory depth rather than 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] n;
        if (a >= LAST_L) begin
            n = '0;
        end else begin
            n = a + ADDR_W'(1);
        end
        return n;
    endfunction

    assign cmd_s         = din[DATA_W+1:DATA_W];
    assign payload_s     = din[DATA_W-1:0];
    assign addr_s        = payload_s[ADDR_W-1:0];
    // rx_ready depends on state only so the upstream can never create a
    // combinational loop through rx_valid.
    assign rx_ready      = (state_r == ST_IDLE);
    assign accept_s      = rx_valid & rx_ready;
    assign wr_in_range_s = ({1'b0, wr_add_r} < DEPTH_L);
    assign rd_in_range_s = ({1'b0, rd_add_r} < DEPTH_L);
    // Only meaningful when the pointer is in range; the slice then holds the
    // full address because MEM_DEPTH <= 2**ADDR_W.
    assign wr_idx_s      = wr_add_r[IDX_W-1:0];
    assign rd_idx_s      = rd_add_r[IDX_W-1:0];

    assign dout          = dout_r;
    assign tx_valid      = tx_valid_r;
    assign err           = err_r;

    // Next-state decode for the read sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (cmd_s == CMD_RD_DATA)) begin
                    state_nxt_s = ST_RD_MEM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_MEM: begin
                state_nxt_s = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (tx_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RD_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered tx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tx_valid_r <= (state_nxt_s == ST_RD_OUT);
        end
    end

    // Address pointers: loaded by address commands, advanced after data access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_add_r <= '0;
            rd_add_r <= '0;
        end else begin
            if (accept_s) begin
                case (cmd_s)
                    CMD_WR_ADDR: wr_add_r <= addr_s;
                    CMD_WR_DATA: begin
                        if (AUTO_INC != 0) begin
                            wr_add_r <= next_addr(wr_add_r);
                        end
                    end
                    CMD_RD_ADDR: rd_add_r <= addr_s;
                    default: begin
                        // read data: pointer advances in the RD_MEM cycle
                    end
                endcase
            end
            if ((state_r == ST_RD_MEM) && (AUTO_INC != 0)) begin
                rd_add_r <= next_addr(rd_add_r);
            end
        end
    end

    // Read data capture; dout only changes in the RD_MEM cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= '0;
        end else if (state_r == ST_RD_MEM) begin
            dout_r <= rd_in_range_s ? mem_r[rd_idx_s] : '0;
        end
    end

    // Error pulse: raised the cycle after an offending command is accepted
    // (for reads that is the RD_MEM cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= accept_s &
                     (((cmd_s == CMD_WR_DATA) & ~wr_in_range_s) |
                      ((cmd_s == CMD_RD_DATA) & ~rd_in_range_s));
        end
    end

    // Memory array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_s && (cmd_s == CMD_WR_DATA) && wr_in_range_s) begin
            mem_r[wr_idx_s] <= payload_s;
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: three instances (256/auto-inc, 200/auto-inc,
// 256/static pointers) share one stimulus stream. A transaction-level model
// per instance predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_spi_ram_ctrl;

    logic              clk;
    logic              rst_n;
    logic [9:0]        din;
    logic              rx_valid;
    logic              tx_ready;
    logic [2:0]        rdy_v;
    logic [2:0]        txv_v;
    logic [2:0]        err_v;
    logic [2:0][7:0]   dout_v;

    int n_chk  = 0;
    int n_fail = 0;

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) u_a (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rdy_v[0]),
        .dout(dout_v[0]), .tx_valid(txv_v[0]), .tx_ready(tx_ready), .err(err_v[0]));
    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rdy_v[1]),
        .dout(dout_v[1]), .tx_valid(txv_v[1]), .tx_ready(tx_ready), .err(err_v[1]));
    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) u_c (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .rx_ready(rdy_v[2]),
        .dout(dout_v[2]), .tx_valid(txv_v[2]), .tx_ready(tx_ready), .err(err_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int depth_of(input int c);
        return (c == 1) ? 200 : 256;
    endfunction

    function automatic bit inc_of(input int c);
        return (c != 2);
    endfunction

    function automatic int nxt(input int a, input int d);
        return (a >= d - 1) ? 0 : a + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 = accepting commands, 1 = fetching, 2 = result offered.
    int         m_phase;
    int         m_wr [3];
    int         m_rd [3];
    logic [7:0] m_mem [3][256];
    logic [7:0] m_dout [3];
    logic       m_err [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            for (int c = 0; c < 3; c++) begin
                m_wr[c] <= 0; m_rd[c] <= 0; m_dout[c] <= 8'h00; m_err[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 3; c++) m_err[c] <= 1'b0;
            if (m_phase == 0 && rx_valid) begin
                for (int c = 0; c < 3; c++) begin
                    case (din[9:8])
                        2'b00: m_wr[c] <= int'(din[7:0]);
                        2'b01: begin
                            if (m_wr[c] < depth_of(c)) m_mem[c][m_wr[c]] <= din[7:0];
                            else m_err[c] <= 1'b1;
                            if (inc_of(c)) m_wr[c] <= nxt(m_wr[c], depth_of(c));
                        end
                        2'b10: m_rd[c] <= int'(din[7:0]);
                        default: m_err[c] <= (m_rd[c] >= depth_of(c));
                    endcase
                end
                if (din[9:8] == 2'b11) m_phase <= 1;
            end else if (m_phase == 1) begin
                for (int c = 0; c < 3; c++) begin
                    m_dout[c] <= (m_rd[c] < depth_of(c)) ? m_mem[c][m_rd[c]] : 8'h00;
                    if (inc_of(c)) m_rd[c] <= nxt(m_rd[c], depth_of(c));
                end
                m_phase <= 2;
            end else if (m_phase == 2 && tx_ready) begin
                m_phase <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rx_ready[%0d]", c), 32'(rdy_v[c]), 32'(m_phase == 0));
            chk($sformatf("tx_valid[%0d]", c), 32'(txv_v[c]), 32'(m_phase == 2));
            chk($sformatf("dout[%0d]", c), 32'(dout_v[c]), 32'(m_dout[c]));
            chk($sformatf("err[%0d]", c), 32'(err_v[c]), 32'(m_err[c]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] c, input logic [7:0] p);
        int n;
        n = 0;
        @(negedge clk);
        din = {c, p};
        rx_valid = 1'b1;
        while (!rdy_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Issue a read with tx_ready high; returns dout and err seen per instance.
    task automatic do_read(output logic [2:0][7:0] d, output logic [2:0] e);
        send(2'b11, 8'h00);
        e = err_v;
        @(negedge clk);
        @(negedge clk);
        chk("rd_latency_txv", 32'(txv_v[0]), 32'd1);
        d = dout_v;
        @(negedge clk);
        chk("rd_txv_drop", 32'(txv_v[0]), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][7:0] d;
        logic [2:0]      e;
        rst_n = 1'b0; rx_valid = 1'b0; din = 10'd0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dout", 32'(dout_v[0]), 32'd0);
        chk("reset_txv", 32'(txv_v), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rdy", 32'(rdy_v), 32'h7);

        // fill memory: mem[a] = a ^ 0x5A
        for (int a = 0; a < 256; a++) begin
            send(2'b00, 8'(a));
            send(2'b01, 8'(a) ^ 8'h5A);
        end

        // basic write then read
        send(2'b00, 8'h10); send(2'b01, 8'hA5); send(2'b10, 8'h10);
        do_read(d, e);
        chk("wr_rd_A5", 32'(d[0]), 32'h0000_00A5);

        // auto-increment burst across the top of the address space
        send(2'b00, 8'hFE);
        send(2'b01, 8'h11); send(2'b01, 8'h22); send(2'b01, 8'h33);
        send(2'b10, 8'hFE);
        do_read(d, e); chk("burst0", 32'(d[0]), 32'h11);
        do_read(d, e); chk("burst1", 32'(d[0]), 32'h22);
        do_read(d, e); chk("burst2", 32'(d[0]), 32'h33);

        // backpressure: result held, rx blocked, write ignored
        tx_ready = 1'b0;
        send(2'b10, 8'hFE);
        send(2'b11, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din = {2'b01, 8'h77};
            rx_valid = 1'b1;
            chk("bp_rdy", 32'(rdy_v[0]), 32'd0);
            chk("bp_txv", 32'(txv_v[0]), 32'd1);
            chk("bp_dout", 32'(dout_v[0]), 32'h11);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        send(2'b10, 8'h01);
        do_read(d, e);
        chk("bp_no_write", 32'(d[0]), 32'h5B);

        // range checks on the 200-deep instance
        send(2'b00, 8'hC8);
        send(2'b01, 8'h99);
        chk("range_wr_err", 32'(err_v[1]), 32'd1);
        chk("range_wr_noerr", 32'(err_v[0]), 32'd0);
        send(2'b10, 8'hC8);
        do_read(d, e);
        chk("range_rd_err", 32'(e[1]), 32'd1);
        chk("range_rd_dout", 32'(d[1]), 32'd0);
        chk("range_rd_A", 32'(d[0]), 32'h99);
        send(2'b00, 8'hC7); send(2'b01, 8'h44); send(2'b01, 8'h55);
        send(2'b10, 8'h00);
        do_read(d, e);
        chk("range_wrap", 32'(d[1]), 32'h55);

        // static pointers on the AUTO_INC=0 instance
        send(2'b00, 8'h05); send(2'b01, 8'h01); send(2'b01, 8'h02);
        send(2'b10, 8'h05);
        do_read(d, e); chk("noinc_last", 32'(d[2]), 32'h02);
        send(2'b01, 8'h03);
        do_read(d, e); chk("noinc_ptr", 32'(d[2]), 32'h03);

        // reset while a result is being offered
        tx_ready = 1'b0;
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        repeat (2) @(negedge clk);
        chk("pre_rst_txv", 32'(txv_v[0]), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("rst_txv", 32'(txv_v), 32'd0);
        chk("rst_dout", 32'(dout_v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'(rdy_v), 32'h7);
        send(2'b01, 8'hC3);
        do_read(d, e);
        chk("rst_ptr_a", 32'(d[0]), 32'hC3);
        chk("rst_ptr_b", 32'(d[1]), 32'hC3);
        chk("rst_ptr_c", 32'(d[2]), 32'hC3);

        // randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rx_valid = ($urandom_range(0, 3) != 0);
            din      = 10'($urandom_range(0, 1023));
            tx_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
